// File: rtl/wb_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module : wb_pkg
// Brief  : Shared writeback kinds, select codes, states and kind decode.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam logic [3:0] KIND_ALU_R = 4'd0;
  localparam logic [3:0] KIND_ALU_I = 4'd1;
  localparam logic [3:0] KIND_MFHI  = 4'd2;
  localparam logic [3:0] KIND_MFLO  = 4'd3;
  localparam logic [3:0] KIND_LOAD  = 4'd4;
  localparam logic [3:0] KIND_EXC   = 4'd5;
  localparam logic [3:0] KIND_MOVD  = 4'd6;
  localparam logic [3:0] KIND_SLT   = 4'd7;
  localparam logic [3:0] KIND_JAL   = 4'd8;
  localparam logic [3:0] KIND_LUI   = 4'd9;

  localparam logic [3:0] SEL_ALUOUT = 4'd0;
  localparam logic [3:0] SEL_HIGH   = 4'd1;
  localparam logic [3:0] SEL_LOW    = 4'd2;
  localparam logic [3:0] SEL_MDR    = 4'd3;
  localparam logic [3:0] SEL_C227   = 4'd4;
  localparam logic [3:0] SEL_REGDES = 4'd5;
  localparam logic [3:0] SEL_LT     = 4'd6;
  localparam logic [3:0] SEL_PC     = 4'd7;
  localparam logic [3:0] SEL_SL16   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_MDR_LOAD = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } wb_state_t;

  typedef enum logic [1:0] {
    DST_RD   = 2'd0,
    DST_RT   = 2'd1,
    DST_LINK = 2'd2,
    DST_NONE = 2'd3
  } wb_dst_src_t;

  typedef struct packed {
    logic        legal;
    logic        load;
    logic [3:0]  sel;
    wb_dst_src_t dst_src;
  } wb_decode_t;

  function automatic wb_decode_t wb_decode(input logic [3:0] kind);
    wb_decode_t d;
    d.legal   = 1'b1;
    d.load    = 1'b0;
    d.sel     = SEL_ALUOUT;
    d.dst_src = DST_RD;
    case (kind)
      KIND_ALU_R: begin d.sel = SEL_ALUOUT; d.dst_src = DST_RD;   end
      KIND_ALU_I: begin d.sel = SEL_ALUOUT; d.dst_src = DST_RT;   end
      KIND_MFHI:  begin d.sel = SEL_HIGH;   d.dst_src = DST_RD;   end
      KIND_MFLO:  begin d.sel = SEL_LOW;    d.dst_src = DST_RD;   end
      KIND_LOAD:  begin d.sel = SEL_MDR;    d.dst_src = DST_RT; d.load = 1'b1; end
      KIND_EXC:   begin d.sel = SEL_C227;   d.dst_src = DST_LINK; end
      KIND_MOVD:  begin d.sel = SEL_REGDES; d.dst_src = DST_RD;   end
      KIND_SLT:   begin d.sel = SEL_LT;     d.dst_src = DST_RD;   end
      KIND_JAL:   begin d.sel = SEL_PC;     d.dst_src = DST_LINK; end
      KIND_LUI:   begin d.sel = SEL_SL16;   d.dst_src = DST_RT;   end
      default:    begin d.legal = 1'b0;     d.dst_src = DST_NONE; end
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : wb_sequencer_if
// Brief  : Request/writeback signal bundle between control FSM and sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_sequencer_if;
  logic       start;
  logic [3:0] wb_kind;
  logic [4:0] rd;
  logic [4:0] rt;
  logic       busy;
  logic       done;
  logic       err;
  logic       mem_read;
  logic       mdr_write;
  logic [3:0] memto_reg;
  logic [4:0] reg_dst;
  logic       reg_write;

  // master: the requesting control FSM; slave: the writeback sequencer
  modport master (
    output start, wb_kind, rd, rt,
    input  busy, done, err, mem_read, mdr_write, memto_reg, reg_dst, reg_write
  );

  modport slave (
    input  start, wb_kind, rd, rt,
    output busy, done, err, mem_read, mdr_write, memto_reg, reg_dst, reg_write
  );
endinterface

`default_nettype wire

// File: rtl/wb_sequencer.sv
//------------------------------------------------------------------------------
// Module : wb_sequencer
// Brief  : Sequences one register writeback per start, with memory wait for loads.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_sequencer
  import wb_pkg::*;
#(
  parameter int         MEM_LAT  = 2,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  wire logic     clk,
  input  wire logic     reset,
  wb_sequencer_if.slave bus
);

  localparam logic [3:0] c_cnt_init = 4'(MEM_LAT - 1);

  wb_state_t  r_state;
  wb_state_t  w_next;
  logic [3:0] r_cnt;
  logic [3:0] r_sel;
  logic [4:0] r_dst;

  wb_decode_t w_dec;
  logic [4:0] w_dst_cap;
  logic       w_accept;

  logic       w_busy;
  logic       w_done;
  logic       w_err;
  logic       w_mem_read;
  logic       w_mdr_write;
  logic [3:0] w_memto_reg;
  logic [4:0] w_reg_dst;
  logic       w_reg_write;

  assign w_dec    = wb_decode(bus.wb_kind);
  assign w_accept = (r_state == ST_IDLE) && bus.start;

  always_comb begin
    w_dst_cap = 5'd0;
    case (w_dec.dst_src)
      DST_RD:   w_dst_cap = bus.rd;
      DST_RT:   w_dst_cap = bus.rt;
      DST_LINK: w_dst_cap = LINK_REG;
      default:  w_dst_cap = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request fields are frozen at acceptance; bus inputs are ignored afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
      r_sel <= 4'd0;
      r_dst <= 5'd0;
    end else if (w_accept) begin
      r_sel <= w_dec.sel;
      r_dst <= w_dst_cap;
      r_cnt <= (w_dec.legal && w_dec.load) ? c_cnt_init : 4'd0;
    end else if ((r_state == ST_MEM_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_busy      = (r_state != ST_IDLE);
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_mem_read  = 1'b0;
    w_mdr_write = 1'b0;
    w_memto_reg = 4'd0;
    w_reg_dst   = 5'd0;
    w_reg_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (!w_dec.legal) begin
            w_next = ST_ERR;
          end else if (w_dec.load) begin
            w_next = ST_MEM_WAIT;
          end else begin
            w_next = ST_WRITE;
          end
        end
      end
      ST_MEM_WAIT: begin
        w_mem_read = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next = ST_MDR_LOAD;
        end
      end
      ST_MDR_LOAD: begin
        w_mdr_write = 1'b1;
        w_next      = ST_WRITE;
      end
      ST_WRITE: begin
        w_memto_reg = r_sel;
        w_reg_dst   = r_dst;
        // $zero is architecturally read-only
        w_reg_write = (r_dst != 5'd0);
        w_next      = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        w_err  = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = w_err;
  assign bus.mem_read  = w_mem_read;
  assign bus.mdr_write = w_mdr_write;
  assign bus.memto_reg = w_memto_reg;
  assign bus.reg_dst   = w_reg_dst;
  assign bus.reg_write = w_reg_write;

endmodule

`default_nettype wire
